// File: rtl/tmr_monitor_pkg.sv
// Shared replica indices, flag vector type and helpers for the TMR word voter/monitor.
package tmr_monitor_pkg;

    localparam int RepA        = 0;
    localparam int RepB        = 1;
    localparam int RepC        = 2;
    localparam int NumReplicas = 3;

    typedef logic [NumReplicas-1:0] rep_flags_t;

    // True when at least two replicas disagree with the vote.
    function automatic logic at_least_two(input rep_flags_t f);
        return (f[RepA] & f[RepB]) | (f[RepA] & f[RepC]) | (f[RepB] & f[RepC]);
    endfunction

endpackage

// File: rtl/tmr_word_majority.sv
// Bitwise 2-of-3 majority vote over three replica words with per-replica mismatch flags.
module tmr_word_majority
    import tmr_monitor_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] data_a_i,
    input  logic [DataWidth-1:0] data_b_i,
    input  logic [DataWidth-1:0] data_c_i,
    output logic [DataWidth-1:0] voted_o,
    output rep_flags_t           err_o,
    output logic                 multi_err_o
);

    logic [DataWidth-1:0] voted;

    assign voted = (data_a_i & data_b_i) | (data_a_i & data_c_i) | (data_b_i & data_c_i);

    assign voted_o     = voted;
    assign err_o[RepA] = |(data_a_i ^ voted);
    assign err_o[RepB] = |(data_b_i ^ voted);
    assign err_o[RepC] = |(data_c_i ^ voted);
    assign multi_err_o = at_least_two(err_o);

endmodule

// File: rtl/tmr_word_voter_monitor.sv
// TMR word voter with optional output register, saturating per-replica error
// counters, consecutive-mismatch run counters and sticky fault flags.
module tmr_word_voter_monitor
    import tmr_monitor_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int CntWidth       = 8,
    parameter int FaultThreshold = 4,
    parameter bit OutputReg      = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_a_i,
    input  logic [DataWidth-1:0] data_b_i,
    input  logic [DataWidth-1:0] data_c_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    output rep_flags_t           err_o,
    output logic                 multi_err_o,
    output rep_flags_t           fault_o,
    output logic [CntWidth-1:0]  err_cnt_a_o,
    output logic [CntWidth-1:0]  err_cnt_b_o,
    output logic [CntWidth-1:0]  err_cnt_c_o
);

    localparam int                RunWidth = $clog2(FaultThreshold + 1);
    localparam logic [RunWidth-1:0] RunMax = RunWidth'(FaultThreshold);
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [DataWidth-1:0] voted;
    rep_flags_t           err_raw;
    logic                 multi_raw;
    rep_flags_t           err_s;
    logic                 multi_s;

    tmr_word_majority #(
        .DataWidth (DataWidth)
    ) u_majority (
        .data_a_i    (data_a_i),
        .data_b_i    (data_b_i),
        .data_c_i    (data_c_i),
        .voted_o     (voted),
        .err_o       (err_raw),
        .multi_err_o (multi_raw)
    );

    // Idle cycles report no mismatch but still present the voted word.
    assign err_s   = valid_i ? err_raw : '0;
    assign multi_s = valid_i & multi_raw;

    generate
        if (OutputReg) begin : g_out_reg
            logic                 valid_q;
            logic [DataWidth-1:0] data_q;
            rep_flags_t           err_q;
            logic                 multi_q;

            // NOTE: every flop has an explicit reset value; non-blocking (<=) for all state.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    err_q   <= '0;
                    multi_q <= 1'b0;
                end else begin
                    valid_q <= valid_i;
                    data_q  <= voted;
                    err_q   <= err_s;
                    multi_q <= multi_s;
                end
            end

            assign valid_o     = valid_q;
            assign data_o      = data_q;
            assign err_o       = err_q;
            assign multi_err_o = multi_q;
        end else begin : g_out_comb
            // Combinational path still honours the all-zero-in-reset contract.
            assign valid_o     = valid_i & ~rst_i;
            assign data_o      = rst_i ? '0 : voted;
            assign err_o       = rst_i ? '0 : err_s;
            assign multi_err_o = multi_s & ~rst_i;
        end
    endgenerate

    logic [NumReplicas-1:0][CntWidth-1:0] cnt_vec;
    rep_flags_t                           fault_vec;

    generate
        for (genvar r = 0; r < NumReplicas; r++) begin : g_rep
            logic [RunWidth-1:0] run_q, run_d;
            logic [CntWidth-1:0] cnt_q, cnt_d;
            logic                fault_q, fault_d;

            always_comb begin
                // NOTE: hold-by-default assignments first keep this block latch-free.
                run_d   = run_q;
                cnt_d   = cnt_q;
                fault_d = fault_q;
                if (clear_i) begin
                    run_d   = '0;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end else if (valid_i) begin
                    if (err_s[r]) begin
                        if (run_q != RunMax) run_d = run_q + 1'b1;
                        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                        if (run_d == RunMax) fault_d = 1'b1;
                    end else begin
                        run_d = '0;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    run_q   <= '0;
                    cnt_q   <= '0;
                    fault_q <= 1'b0;
                end else begin
                    run_q   <= run_d;
                    cnt_q   <= cnt_d;
                    fault_q <= fault_d;
                end
            end

            assign cnt_vec[r]   = cnt_q;
            assign fault_vec[r] = fault_q;
        end
    endgenerate

    assign fault_o     = fault_vec;
    assign err_cnt_a_o = cnt_vec[RepA];
    assign err_cnt_b_o = cnt_vec[RepB];
    assign err_cnt_c_o = cnt_vec[RepC];

endmodule

// File: tb/tb_tmr_word_voter_monitor.sv
// Scoreboard bench: three DUT configurations (default, CntWidth=2, OutputReg=0) share data inputs.
module tb_tmr_word_voter_monitor;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
        logic       multi;
        logic [2:0] fault;
        logic [7:0] ca;
        logic [7:0] cb;
        logic [7:0] cc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] da, db, dc;
    logic [2:0] valid, clear;

    logic [2:0] vo;
    logic [7:0] data0, data1, data2;
    logic [2:0] err0, err1, err2;
    logic [2:0] multi;
    logic [2:0] fault0, fault1, fault2;
    logic [7:0] ca0, cb0, cc0, ca2, cb2, cc2;
    logic [1:0] ca1, cb1, cc1;

    exp_t q0[$], q1[$], q2[$];
    int   errors = 0;
    int   checks = 0;

    tmr_word_voter_monitor #(.DataWidth(8), .CntWidth(8), .FaultThreshold(4), .OutputReg(1'b1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid[0]), .data_a_i(da), .data_b_i(db), .data_c_i(dc),
        .clear_i(clear[0]), .valid_o(vo[0]), .data_o(data0), .err_o(err0), .multi_err_o(multi[0]),
        .fault_o(fault0), .err_cnt_a_o(ca0), .err_cnt_b_o(cb0), .err_cnt_c_o(cc0));

    tmr_word_voter_monitor #(.DataWidth(8), .CntWidth(2), .FaultThreshold(4), .OutputReg(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid[1]), .data_a_i(da), .data_b_i(db), .data_c_i(dc),
        .clear_i(clear[1]), .valid_o(vo[1]), .data_o(data1), .err_o(err1), .multi_err_o(multi[1]),
        .fault_o(fault1), .err_cnt_a_o(ca1), .err_cnt_b_o(cb1), .err_cnt_c_o(cc1));

    tmr_word_voter_monitor #(.DataWidth(8), .CntWidth(8), .FaultThreshold(4), .OutputReg(1'b0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid[2]), .data_a_i(da), .data_b_i(db), .data_c_i(dc),
        .clear_i(clear[2]), .valid_o(vo[2]), .data_o(data2), .err_o(err2), .multi_err_o(multi[2]),
        .fault_o(fault2), .err_cnt_a_o(ca2), .err_cnt_b_o(cb2), .err_cnt_c_o(cc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary, got %0d errors of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an output with no expected entry, expected none", name);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic [2:0] e, input logic m,
                                input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c);
        exp_t x;
        x.data = d; x.err = e; x.multi = m; x.fault = f; x.ca = a; x.cb = b; x.cc = c;
        return x;
    endfunction

    task automatic step(input int dut, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic v, input logic clr, input exp_t e);
        @(posedge clk);
        #1;
        da = a; db = b; dc = c;
        valid = '0; clear = '0;
        valid[dut] = v;
        clear[dut] = clr;
        if (v) begin
            case (dut)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic idle();
        step(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, '0);
    endtask

    // Monitors: pop and compare whenever a DUT presents a valid output.
    always @(negedge clk) begin
        if (vo[0]) begin
            if (q0.size() == 0) unexpected("dut0");
            else check("dut0", {data0, err0, multi[0], fault0, ca0, cb0, cc0}, q0.pop_front());
        end
        if (vo[1]) begin
            if (q1.size() == 0) unexpected("dut1");
            else check("dut1", {data1, err1, multi[1], fault1, 6'b0, ca1, 6'b0, cb1, 6'b0, cc1}, q1.pop_front());
        end
        if (vo[2]) begin
            if (q2.size() == 0) unexpected("dut2");
            else check("dut2", {data2, err2, multi[2], fault2, ca2, cb2, cc2}, q2.pop_front());
        end
    end

    initial begin
        rst = 1'b1; valid = 3'b111; clear = '0;
        da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dut0", {vo[0], data0, err0, multi[0], fault0, ca0, cb0, cc0}, '0);
        check("rst_dut1", {vo[1], data1, err1, multi[1], fault1, ca1, cb1, cc1}, '0);
        check("rst_dut2", {vo[2], data2, err2, multi[2], fault2, ca2, cb2, cc2}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0; valid = '0;

        // Clean vote, then a single A mismatch.
        step(0, 8'hA5, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b000, 0, 3'b000, 0, 0, 0));
        step(0, 8'hA4, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b001, 0, 3'b000, 1, 0, 0));
        repeat (3) step(0, 8'hA5, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b000, 0, 3'b000, 1, 0, 0));
        // Run of 4 A mismatches spanning an idle gap sets fault A.
        for (int i = 0; i < 3; i++)
            step(0, 8'hA4, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b001, 0, 3'b000, 8'(2 + i), 0, 0));
        idle(); idle();
        step(0, 8'hA4, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b001, 0, 3'b001, 5, 0, 0));
        step(0, 8'hA5, 8'hA5, 8'hA5, 0, 1, '0);
        // Same run broken by one clean sample: no fault.
        for (int i = 0; i < 3; i++)
            step(0, 8'hA4, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b001, 0, 3'b000, 8'(1 + i), 0, 0));
        idle(); idle();
        step(0, 8'hA5, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b000, 0, 3'b000, 3, 0, 0));
        step(0, 8'hA4, 8'hA5, 8'hA5, 1, 0, mk(8'hA5, 3'b001, 0, 3'b000, 4, 0, 0));
        // Multi-replica mismatches, all replicas counted in one cycle.
        step(0, 8'h01, 8'h02, 8'h00, 1, 0, mk(8'h00, 3'b011, 1, 3'b000, 5, 1, 0));
        step(0, 8'h01, 8'h02, 8'h04, 1, 0, mk(8'h00, 3'b111, 1, 3'b000, 6, 2, 1));
        step(0, 8'h01, 8'h02, 8'h04, 1, 0, mk(8'h00, 3'b111, 1, 3'b001, 7, 3, 2));
        idle();

        // CntWidth=2: saturation at 3, fault B at run 4, clear beats a mismatch.
        for (int i = 0; i < 5; i++)
            step(1, 8'h00, 8'h01, 8'h00, 1, 0,
                 mk(8'h00, 3'b010, 0, (i >= 3) ? 3'b010 : 3'b000, 0, (i >= 2) ? 8'd3 : 8'(i + 1), 0));
        step(1, 8'h00, 8'h01, 8'h00, 1, 1, mk(8'h00, 3'b010, 0, 3'b000, 0, 0, 0));
        step(1, 8'h00, 8'h01, 8'h00, 1, 0, mk(8'h00, 3'b010, 0, 3'b000, 0, 1, 0));
        idle();

        // OutputReg=0: same-cycle outputs, counters show pre-sample state.
        step(2, 8'hFF, 8'h0F, 8'hF0, 1, 0, mk(8'hFF, 3'b110, 1, 3'b000, 0, 0, 0));
        step(2, 8'hFF, 8'h0F, 8'hF0, 1, 0, mk(8'hFF, 3'b110, 1, 3'b000, 0, 1, 1));
        step(2, 8'hFF, 8'h0F, 8'hF0, 0, 0, '0);
        @(negedge clk);
        #1;
        check("dut2_idle", {vo[2], data2, err2, multi[2], cb2, cc2}, {1'b0, 8'hFF, 3'b000, 1'b0, 8'd2, 8'd2});
        rst = 1'b1;
        #1;
        check("dut2_async_rst", {fault2, ca2, cb2, cc2, data2}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2, 8'hFF, 8'h0F, 8'hF0, 1, 0, mk(8'hFF, 3'b110, 1, 3'b000, 0, 0, 0));
        step(2, 8'hFF, 8'h0F, 8'hF0, 1, 0, mk(8'hFF, 3'b110, 1, 3'b000, 0, 1, 1));
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
